// File: rtl/nexys4_disp_axil_slave.sv
// AXI4-Lite slave with four registers driving an 8-digit multiplexed 7-segment display.
// Build option: define NEXYS4_DISP_WSTRB_EN to honour wstrb byte lanes; undefined, every write updates all lanes.
module nexys4_disp_axil_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int REFRESH_DIV          = 100000
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [7:0]                        an_n,
  output logic [6:0]                        seg_n,
  output logic                              dp_n
);

  localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] digits_q, digits_d, ctrl_q, ctrl_d;
  logic [7:0]  enable_q, enable_d, dots_q, dots_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        aw_fire, w_fire, ar_fire, wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data, wr_mask, wr_cur, wr_merge, rd_word;
  logic [3:0]  wr_strb;
  logic        unused_inputs;

  // Assertion is immediate; release waits two clocks so every flop leaves reset on the same edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rst_sync_q <= 2'b00;
    else                  rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // A channel captured in this very cycle counts as held, so the write can fire on the same edge.
  assign aw_fire = s00_axi_awvalid && awready_q;
  assign w_fire  = s00_axi_wvalid && wready_q;
  assign ar_fire = s00_axi_arvalid && arready_q;
  assign wr_en   = (aw_held_q || aw_fire) && (w_held_q || w_fire) && !bvalid_q;
  assign wr_addr = aw_held_q ? awaddr_q : s00_axi_awaddr[3:2];
  assign wr_data = w_held_q ? wdata_q : s00_axi_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s00_axi_wstrb;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
`ifdef NEXYS4_DISP_WSTRB_EN
      assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
`else
      assign wr_mask[gi*8 +: 8] = 8'hFF;
`endif
    end
  endgenerate

`ifdef NEXYS4_DISP_WSTRB_EN
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0], wr_strb};
`endif

  always_comb begin
    case (wr_addr)
      2'd0:    wr_cur = digits_q;
      2'd1:    wr_cur = {24'd0, enable_q};
      2'd2:    wr_cur = {24'd0, dots_q};
      default: wr_cur = ctrl_q;
    endcase
    case (s00_axi_araddr[3:2])
      2'd0:    rd_word = digits_q;
      2'd1:    rd_word = {24'd0, enable_q};
      2'd2:    rd_word = {24'd0, dots_q};
      default: rd_word = ctrl_q;
    endcase
  end
  assign wr_merge = (wr_cur & ~wr_mask) | (wr_data & wr_mask);

  always_comb begin
    awready_d = s00_axi_awvalid && !awready_q && !aw_held_q && !bvalid_q;
    wready_d  = s00_axi_wvalid && !wready_q && !w_held_q && !bvalid_q;
    aw_held_d = !wr_en && (aw_held_q || aw_fire);
    w_held_d  = !wr_en && (w_held_q || w_fire);
    awaddr_d  = aw_fire ? s00_axi_awaddr[3:2] : awaddr_q;
    wdata_d   = w_fire ? s00_axi_wdata : wdata_q;
    wstrb_d   = w_fire ? s00_axi_wstrb : wstrb_q;
    bvalid_d  = wr_en || (bvalid_q && !s00_axi_bready);
    arready_d = s00_axi_arvalid && !arready_q && !rvalid_q;
    rvalid_d  = ar_fire || (rvalid_q && !s00_axi_rready);
    rdata_d   = ar_fire ? rd_word : rdata_q;
    digits_d  = digits_q;
    enable_d  = enable_q;
    dots_d    = dots_q;
    ctrl_d    = ctrl_q;
    if (wr_en) begin
      case (wr_addr)
        2'd0:    digits_d = wr_merge;
        2'd1:    enable_d = wr_merge[7:0];
        2'd2:    dots_d   = wr_merge[7:0];
        default: ctrl_d   = wr_merge;
      endcase
    end
    cnt_d = (cnt_q == CNT_MAX) ? 20'd0 : cnt_q + 20'd1;
    idx_d = (cnt_q == CNT_MAX) ? idx_q + 3'd1 : idx_q;
    an_d  = (enable_q[idx_q] && ctrl_q[0]) ? ~(8'h01 << idx_q) : 8'hFF;
    seg_d = hex_to_seg(digits_q[idx_q*4 +: 4]);
    dp_d  = ~dots_q[idx_q];
  end

  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
      arready_q <= 1'b0;  rvalid_q <= 1'b0;
      aw_held_q <= 1'b0;  w_held_q <= 1'b0;
      awaddr_q  <= 2'd0;  wdata_q  <= 32'd0; wstrb_q  <= 4'd0;  rdata_q <= 32'd0;
      digits_q  <= 32'd0; enable_q <= 8'd0;  dots_q   <= 8'd0;  ctrl_q  <= 32'd0;
      cnt_q     <= 20'd0; idx_q    <= 3'd0;
      an_q      <= 8'hFF; seg_q    <= 7'h7F; dp_q     <= 1'b1;
    end else begin
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d;
      aw_held_q <= aw_held_d; w_held_q <= w_held_d;
      awaddr_q  <= awaddr_d;  wdata_q  <= wdata_d;  wstrb_q  <= wstrb_d;  rdata_q <= rdata_d;
      digits_q  <= digits_d;  enable_q <= enable_d; dots_q   <= dots_d;   ctrl_q  <= ctrl_d;
      cnt_q     <= cnt_d;     idx_q    <= idx_d;
      an_q      <= an_d;      seg_q    <= seg_d;    dp_q     <= dp_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign an_n            = an_q;
  assign seg_n           = seg_q;
  assign dp_n            = dp_q;

endmodule

// File: doc/nexys4_disp_axil_slave.md
NEXYS4_DISP_AXIL_SLAVE -- requirements
Module: nexys4_disp_axil_slave

Interface
REQ-001 The block SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 4: byte address width covering four 32-bit registers.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot; legal range 2 to 2^20.
REQ-004 Clock and reset SHALL be: s00_axi_aclk in 1, the one clock; s00_axi_aresetn in 1, asynchronous, active-low reset.
REQ-005 The write address ports SHALL be: s00_axi_awaddr in 4; s00_axi_awprot in 3, ignored; s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-006 The write data ports SHALL be: s00_axi_wdata in 32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-007 The write response ports SHALL be: s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-008 The read address ports SHALL be: s00_axi_araddr in 4; s00_axi_arprot in 3, ignored; s00_axi_arvalid in 1; s00_axi_arready out 1.
REQ-009 The read data ports SHALL be: s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.
REQ-010 The display ports SHALL be: an_n out 8, anode select, active-low; seg_n out 7, segments a..g in bits 0..6, active-low; dp_n out 1, decimal point, active-low.

Function
REQ-011 Register map, all read/write: 0x0 DIGITS (nibble k = hex digit k); 0x4 ENABLE[7:0], one bit per digit; 0x8 DOTS[7:0]; 0xC CTRL, where bit0 is global display on and bits 31:1 are scratch.
REQ-012 Address decode SHALL use addr[3:2] only; addr[1:0] SHALL be ignored.
REQ-013 Write channel: AW and W are each accepted independently (ready high for one cycle when the matching valid is high and no address or data of that channel is already held).
REQ-014 The register update SHALL occur in the cycle after both address and data are held; bvalid SHALL assert in that same cycle with bresp=OKAY(00).
REQ-015 bvalid SHALL hold until bready is high; no new AW or W SHALL be accepted while bvalid is high.
REQ-016 Read channel: arready SHALL pulse one cycle when arvalid is high and rvalid is low; rdata and rvalid SHALL be registered the next cycle with rresp=OKAY.
REQ-017 rvalid SHALL hold, with rdata stable, until rready is high; no new AR SHALL be accepted while rvalid is high.
REQ-018 When a read and a register write occur in the same cycle to the same register, the read SHALL return the pre-write value.
REQ-019 Register fields SHALL contain exactly the written value; there is no truncation beyond the widths in REQ-011, and ENABLE/DOTS bits 31:8 SHALL read as 0.
REQ-020 Refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, digit index 0..7 SHALL increment, wrapping 7->0.
REQ-021 an_n SHALL be low only at the current index, and only when ENABLE[index] and CTRL[0] are both 1; otherwise an_n SHALL be all ones.
REQ-022 seg_n SHALL be the registered hex-to-7-segment decode (0-F) of the current nibble; dp_n SHALL be ~DOTS[index]; all display outputs SHALL be registered with 1-cycle latency from the index change.

Reset
REQ-023 On asynchronous assertion of s00_axi_aresetn, all registers SHALL clear to 0 and all ready/valid outputs SHALL go low, including mid-transaction; held AW and W SHALL be discarded.
REQ-024 During reset, rdata and bresp/rresp SHALL be 0; the refresh counter and index SHALL be 0; an_n, seg_n and dp_n SHALL be all ones.
REQ-025 Reset SHALL be released synchronously inside the block, with a 2-flop deassertion synchronizer.

Configuration
REQ-026 With NEXYS4_DISP_WSTRB_EN defined, only the byte lanes whose wstrb bit is 1 SHALL be written; undefined, wstrb SHALL be ignored and all four lanes written.

Verification
REQ-027 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read them back -> reads return 0x1, 0x2, 0x3, 0x4, each bresp/rresp=00.
REQ-028 Drive W three cycles before AW for a write of 0xCAFEF00D to 0x0 -> wready pulses once, bvalid appears the cycle after awready, and the readback is 0xCAFEF00D.
REQ-029 Hold bready/rready low for 10 cycles -> bvalid/rvalid stay high, rdata is stable, and arready/awready stay low.
REQ-030 With REFRESH_DIV=4, DIGITS=0x76543210, ENABLE=0xFF, DOTS=0x01, CTRL=1 -> an_n steps FE,FD,...,7F every 4 clocks; seg_n for digit 0 = 0x40; dp_n is low only on slot 0.
REQ-031 With the macro defined, write 0xFFFFFFFF to 0x0, then write 0x00000000 with wstrb=0010 -> readback is 0xFFFF00FF; without the macro, the readback is 0x00000000.
REQ-032 Assert reset while bvalid is pending -> bvalid drops immediately, registers read 0 after release, and an_n reads FF.
